// File: rtl/branch_ctrl_unit_pkg.sv
// Shared constants and types for the ID-stage branch controller.
package structures;
   localparam int FLAG_N = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_V = 2;
   localparam int FLAG_C = 3;

   localparam logic [4:0] XZR_IDX = 5'd31;

   typedef enum logic [1:0] {
      BR_RUN   = 2'd0,
      BR_STALL = 2'd1,
      BR_KILL  = 2'd2
   } br_ctrl_state_t;
endpackage

// File: rtl/branch_hazard_detect.sv
// Combinational CBZ-operand and flag hazard detection for a branch in ID.
// Optional macro FLAG_FORWARD_EN removes the flag hazard (flags are forwarded instead).
module branch_hazard_detect
   import structures::*;
(
   input  logic       id_branch_valid,
   input  logic       id_blt_op,
   input  logic       id_cbz_op,
   input  logic [4:0] id_rt,
   input  logic       ex_set_flags,
   input  logic       ex_reg_write,
   input  logic [4:0] ex_rd,
   input  logic       mem_mem_read,
   input  logic [4:0] mem_rd,
   output logic       haz_cbz,
   output logic       haz_flag
);
   logic ex_match, mem_match;

   // XZR reads as zero, so a write to it is never a real dependency
   assign ex_match  = ex_reg_write & (ex_rd == id_rt);
   assign mem_match = mem_mem_read & (mem_rd == id_rt);
   assign haz_cbz   = id_branch_valid & id_cbz_op & (id_rt != XZR_IDX) & (ex_match | mem_match);

`ifdef FLAG_FORWARD_EN
   assign haz_flag = 1'b0;
`else
   assign haz_flag = id_branch_valid & id_blt_op & ex_set_flags;
`endif
endmodule

// File: rtl/branch_ctrl_unit.sv
// ID-stage branch sequencing: NZVC flags register, hazard stall, taken-branch kill, perf counters.
// Optional macro FLAG_FORWARD_EN forwards EX flags straight to the condition checker.
module branch_ctrl_unit
   import structures::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_branch_valid,
   input  logic             id_b_type,
   input  logic             id_blt_op,
   input  logic             id_cbz_op,
   input  logic [4:0]       id_rt,
   input  logic             ex_set_flags,
   input  logic [3:0]       ex_flags,
   input  logic             ex_reg_write,
   input  logic [4:0]       ex_rd,
   input  logic             mem_mem_read,
   input  logic [4:0]       mem_rd,
   input  logic             br_taken_in,
   output logic [3:0]       check_flags,
   output logic [3:0]       flags_q,
   output logic             stall_if_id,
   output logic             pc_sel,
   output logic             id_kill,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] kill_cycles
);
   br_ctrl_state_t state, state_nxt;
   logic haz_cbz, haz_flag, hazard;
   logic unused_b_type;

   // The branch type only matters to the condition checker; br_taken_in already reflects it
   assign unused_b_type = id_b_type;

   branch_hazard_detect u_haz (
      .id_branch_valid (id_branch_valid),
      .id_blt_op       (id_blt_op),
      .id_cbz_op       (id_cbz_op),
      .id_rt           (id_rt),
      .ex_set_flags    (ex_set_flags),
      .ex_reg_write    (ex_reg_write),
      .ex_rd           (ex_rd),
      .mem_mem_read    (mem_mem_read),
      .mem_rd          (mem_rd),
      .haz_cbz         (haz_cbz),
      .haz_flag        (haz_flag)
   );

   assign id_kill     = (state == BR_KILL);
   assign hazard      = (haz_cbz | haz_flag) & ~id_kill;
   assign stall_if_id = hazard;
   assign pc_sel      = id_branch_valid & br_taken_in & ~hazard & ~id_kill;

`ifdef FLAG_FORWARD_EN
   assign check_flags = ex_set_flags ? ex_flags : flags_q;
`else
   assign check_flags = flags_q;
`endif

   always_comb begin
      state_nxt = BR_RUN;
      if (!id_kill) begin
         if (hazard)      state_nxt = BR_STALL;
         else if (pc_sel) state_nxt = BR_KILL;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= BR_RUN;
      else       state <= state_nxt;
   end

   // EX keeps advancing under an ID stall, so the flag write is never gated
   always_ff @(posedge clk or posedge reset) begin
      if (reset)             flags_q <= 4'b0000;
      else if (ex_set_flags) flags_q <= ex_flags;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles <= '0;
         kill_cycles  <= '0;
      end else begin
         if (stall_if_id && (stall_cycles != {CNT_W{1'b1}})) stall_cycles <= stall_cycles + 1'b1;
         if (id_kill && (kill_cycles != {CNT_W{1'b1}}))      kill_cycles  <= kill_cycles + 1'b1;
      end
   end
endmodule

// File: doc/branch_ctrl_unit.md
# branch_ctrl_unit

Sequencing controller for conditional-branch resolution in the ID stage of the pipelined 64-bit ARM core. Holds the architectural NZVC flags register and selects the flags presented to the branch condition checker. Detects flag and CBZ-operand hazards and stalls IF/ID until they clear. On a taken branch it redirects the PC and kills the wrong-path instruction. A saturating counter records stall and kill cycles for performance analysis.

## Interface
Parameters:
- CNT_W, 16, width of the stall-cycle and kill-cycle counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; one clock domain (clk).
- id_branch_valid  in  1  a branch instruction (B, B.cond, CBZ) occupies ID.
- id_b_type  in  1  unconditional B.
- id_blt_op  in  1  B.LT.
- id_cbz_op  in  1  CBZ.
- id_rt  in  5  register tested by CBZ.
- ex_set_flags  in  1  instruction in EX writes flags this cycle.
- ex_flags  in  4  ALU flags from EX: [0]=N, [1]=Z, [2]=V, [3]=C.
- ex_reg_write  in  1  instruction in EX writes a register.
- ex_rd  in  5  destination register of the EX instruction.
- mem_mem_read  in  1  load in MEM.
- mem_rd  in  5  destination register of the MEM load.
- br_taken_in  in  1  result from the condition checker, computed on check_flags and ID operands.
- check_flags  out  4  flags fed to the condition checker.
- flags_q  out  4  architectural flags register.
- stall_if_id  out  1  hold PC and IF/ID; insert a bubble into ID/EX.
- pc_sel  out  1  select the branch target for the next PC.
- id_kill  out  1  treat the current ID instruction as a bubble.
- stall_cycles, kill_cycles  out  CNT_W  saturating performance counters.

## Operation
- Hazards (combinational; X31 is never a hazard):
  - haz_cbz = id_branch_valid & id_cbz_op & id_rt!=31 & ((ex_reg_write & ex_rd==id_rt) | (mem_mem_read & mem_rd==id_rt)).
  - haz_flag = id_branch_valid & id_blt_op & ex_set_flags. Present only when forwarding is compiled out.
  - hazard = (haz_cbz | haz_flag) & ~id_kill.
- stall_if_id = hazard.
- pc_sel = id_branch_valid & br_taken_in & ~hazard & ~id_kill.
- Flags register: flags_q <= ex_flags on an edge where ex_set_flags=1. The update is independent of stall and kill, because EX keeps advancing under an ID stall.
- FSM states are RUN, STALL and KILL:
  - RUN: if hazard, go to STALL. Otherwise, if pc_sel, go to KILL. Otherwise stay in RUN.
  - STALL: if hazard, stay in STALL. Otherwise, if pc_sel, go to KILL. Otherwise go to RUN.
  - KILL: id_kill=1 for exactly one cycle. All ID inputs are ignored, so there is no hazard and no pc_sel. Next state is RUN.
- id_kill = (state==KILL). The output is Moore.
- Counters:
  - stall_cycles increments on every edge where stall_if_id=1.
  - kill_cycles increments on every edge where state==KILL.
  - Both saturate at all-ones and never wrap.
- Simultaneous events:
  - A hazard has priority over pc_sel; br_taken_in is ignored while a hazard is present.
  - A flag write in the same cycle as a non-hazard B.LT is covered by forwarding.

## Timing
- Reset values:
  - flags_q = 4'b0000 and state = RUN.
  - Counters are 0.
  - id_kill = 0.
  - check_flags equals the reset flags value.
  - stall_if_id and pc_sel follow their combinational equations.
- Reset mid-KILL or mid-STALL: the block returns to RUN immediately (asynchronous reset).
- The flags register has 1-cycle write latency.
- Taken branch: pc_sel is asserted in cycle T, and id_kill is asserted in cycle T+1. The branch penalty is 1 cycle.
- ALU-to-CBZ hazard: 1 stall cycle, because the producer moves to MEM.
- Load-to-CBZ hazard:
  - Load in EX: 2 stall cycles (EX, then MEM).
  - Load in MEM: 1 stall cycle.

## Configuration
- FLAG_FORWARD_EN:
  - Defined: check_flags = ex_set_flags ? ex_flags : flags_q, and haz_flag is tied to 0.
  - Undefined: check_flags = flags_q, and haz_flag is active. A B.LT directly after a flag-setting instruction stalls for 1 cycle.

## Structure
- The shared package `structures` holds:
  - Flag index constants FLAG_N=0, FLAG_Z=1, FLAG_V=2, FLAG_C=3.
  - The state enum br_ctrl_state_t {BR_RUN, BR_STALL, BR_KILL}.
  - The constant XZR_IDX=31.
- One sub-module: branch_hazard_detect, which is purely combinational and produces haz_cbz and haz_flag.
- The FSM, flags register and counters stay in the top module.

## Test plan
- Reset released with all inputs 0 → flags_q=0, id_kill=0, stall_if_id=0, pc_sel=0, counters=0.
- ex_set_flags=1, ex_flags=4'b0001 → flags_q=4'b0001 on the next edge.
- Same cycle: B.LT in ID and ex_set_flags=1 with ex_flags=4'b0001:
  - With FLAG_FORWARD_EN: check_flags=4'b0001, no stall.
  - Without it: stall_if_id=1 for 1 cycle, stall_cycles=1.
- CBZ with id_rt=5, EX load with ex_rd=5, load then moves to MEM with mem_rd=5 → stall_if_id=1 for exactly 2 cycles, then released.
- Taken B (id_b_type=1, br_taken_in=1) at cycle T → pc_sel=1 at T, id_kill=1 at T+1, state returns to RUN at T+2, kill_cycles=1.
- CBZ with id_rt=31 and ex_rd=31 → no stall. Separately, assert reset during KILL → id_kill drops at once.
